// File: rtl/ov7670_stream_gen_if.sv
// OV7670-style camera stream bundle: control inputs to the generator and the
// byte stream / frame status it produces.
interface ov7670_stream_gen_if;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       ov_vsync;
  logic       ov_href;
  logic [7:0] ov_data;
  logic       frame_done;
  logic [7:0] frame_count;

  // Generator side: takes control, drives the stream.
  modport master (
    input  enable,
    input  pattern_sel,
    output ov_vsync,
    output ov_href,
    output ov_data,
    output frame_done,
    output frame_count
  );

  // Consumer side: drives control, receives the stream.
  modport slave (
    output enable,
    output pattern_sel,
    input  ov_vsync,
    input  ov_href,
    input  ov_data,
    input  frame_done,
    input  frame_count
  );
endinterface

// File: rtl/ov7670_stream_gen.sv
// Camera-style RGB565 test-pattern generator. Emits one byte per clock with
// OV7670-like vsync/href framing: VSYNC, back porch, active lines, front porch.
// Every output is a register loaded from the next-state values, so the
// framing and the pixel byte always line up with the state/column registers.
// H_ACTIVE is expected to be a multiple of 8 (eight equal colour bars).
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned VBP_LINES   = 17,
  parameter int unsigned VFP_LINES   = 10
) (
  input logic                 clk_25_vga,
  input logic                 btn_RESET,
  ov7670_stream_gen_if.master bus
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned COL_W    = $clog2(LINE_LEN);
  localparam int unsigned MAX_AB   = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int unsigned MAX_CD   = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int unsigned LINE_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned LINE_W   = $clog2(LINE_MAX + 1);
  localparam int unsigned BAR_W    = H_ACTIVE / 8;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StVsync  = 3'd1;
  localparam logic [2:0] StVbp    = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StVfp    = 3'd4;

  logic [2:0]        r_state;
  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic [1:0]        r_pat;
  logic              r_vsync;
  logic              r_href;
  logic [7:0]        r_data;
  logic              r_frame_done;
  logic [7:0]        r_frame_count;

  logic [2:0]        w_state_d;
  logic [COL_W-1:0]  w_col_d;
  logic [LINE_W-1:0] w_line_d;
  logic [1:0]        w_pat_d;
  logic [7:0]        w_fc_d;
  logic              w_frame_end;
  logic              w_col_last;
  logic              w_line_last;
  logic [LINE_W-1:0] w_last_line;

  logic              w_href_d;
  logic [COL_W-1:0]  w_x;
  logic [4:0]        w_x5;
  logic [5:0]        w_y6;
  logic [2:0]        w_bar;
  logic [15:0]       w_pix;
  logic [7:0]        w_data_d;

  // Last line index of the current vertical region.
  always_comb begin
    w_last_line = '0;
    case (r_state)
      StVsync:  w_last_line = LINE_W'(VSYNC_LINES - 1);
      StVbp:    w_last_line = LINE_W'(VBP_LINES - 1);
      StActive: w_last_line = LINE_W'(V_ACTIVE - 1);
      StVfp:    w_last_line = LINE_W'(VFP_LINES - 1);
      default:  w_last_line = '0;
    endcase
  end

  assign w_col_last  = (r_col == COL_W'(LINE_LEN - 1));
  assign w_line_last = (r_line == w_last_line);

  // Frame sequencer: column/line counters and region transitions.
  always_comb begin
    w_state_d   = r_state;
    w_col_d     = r_col;
    w_line_d    = r_line;
    w_pat_d     = r_pat;
    w_fc_d      = r_frame_count;
    w_frame_end = 1'b0;
    case (r_state)
      StIdle: begin
        w_col_d  = '0;
        w_line_d = '0;
        if (bus.enable) begin
          w_state_d = StVsync;
          w_pat_d   = bus.pattern_sel;
        end
      end
      StVsync, StVbp, StActive, StVfp: begin
        w_col_d = w_col_last ? '0 : r_col + COL_W'(1);
        if (w_col_last) begin
          if (!w_line_last) begin
            w_line_d = r_line + LINE_W'(1);
          end else begin
            w_line_d = '0;
            case (r_state)
              StVsync:  w_state_d = StVbp;
              StVbp:    w_state_d = StActive;
              StActive: w_state_d = StVfp;
              default: begin
                // End of front porch closes the frame; enable only matters here,
                // so a mid-frame drop still finishes the frame.
                w_frame_end = 1'b1;
                w_fc_d      = r_frame_count + 8'd1;
                if (bus.enable) begin
                  w_state_d = StVsync;
                  w_pat_d   = bus.pattern_sel;
                end else begin
                  w_state_d = StIdle;
                end
              end
            endcase
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_col_d   = '0;
        w_line_d  = '0;
      end
    endcase
  end

  assign w_href_d = (w_state_d == StActive) && (w_col_d < COL_W'(2 * H_ACTIVE));
  assign w_x      = w_col_d >> 1;
  assign w_x5     = 5'(w_x);
  assign w_y6     = 6'(w_line_d);

  // Bar index x/BAR_W, clamped so blanking columns never index past the last bar.
  always_comb begin
    w_bar = 3'(w_x / COL_W'(BAR_W));
    if (w_x >= COL_W'(8 * BAR_W)) begin
      w_bar = 3'd7;
    end
  end

  // Pattern pixel for the next column, using the frame's latched pattern.
  always_comb begin
    w_pix = 16'h0000;
    case (w_pat_d)
      2'd0: begin
        case (w_bar)
          3'd0:    w_pix = 16'hFFFF;
          3'd1:    w_pix = 16'hFFE0;
          3'd2:    w_pix = 16'h07FF;
          3'd3:    w_pix = 16'h07E0;
          3'd4:    w_pix = 16'hF81F;
          3'd5:    w_pix = 16'hF800;
          3'd6:    w_pix = 16'h001F;
          default: w_pix = 16'h0000;
        endcase
      end
      2'd1:    w_pix = 16'hF800;
      2'd2:    w_pix = {w_x5, w_y6, w_x5};
      default: w_pix = (w_x5[4] ^ w_y6[4] ^ w_fc_d[0]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  // Even column carries the high byte, odd column the low byte; zero outside href.
  always_comb begin
    w_data_d = 8'h00;
    if (w_href_d) begin
      w_data_d = w_col_d[0] ? w_pix[7:0] : w_pix[15:8];
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_25_vga or negedge btn_RESET) begin
    if (!btn_RESET) begin
      r_state       <= StIdle;
      r_col         <= '0;
      r_line        <= '0;
      r_pat         <= 2'd0;
      r_vsync       <= 1'b0;
      r_href        <= 1'b0;
      r_data        <= 8'h00;
      r_frame_done  <= 1'b0;
      r_frame_count <= 8'h00;
    end else begin
      r_state       <= w_state_d;
      r_col         <= w_col_d;
      r_line        <= w_line_d;
      r_pat         <= w_pat_d;
      r_vsync       <= (w_state_d == StVsync);
      r_href        <= w_href_d;
      r_data        <= w_data_d;
      r_frame_done  <= w_frame_end;
      r_frame_count <= w_fc_d;
    end
  end

  assign bus.ov_vsync    = r_vsync;
  assign bus.ov_href     = r_href;
  assign bus.ov_data     = r_data;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_count = r_frame_count;

endmodule
